// File: rtl/csr_scan_sequencer.sv
// Serial scan sequencer: moves a CHAIN_LEN-bit image into and out of a CSR scan chain.
// Reads rotate the chain in place; writes and swaps shift a latched image in.
module csr_scan_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 8,
  localparam int unsigned CHAIN_LEN = WIDTH * NREGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] wr_image,
  output logic [CHAIN_LEN-1:0] rd_image,
  output logic                 done,
  output logic                 scan_enable,
  output logic                 scan_in,
  input  logic                 scan_out,
  input  logic                 cpu_wr_enable,
  output logic                 csr_wr_enable,
  output logic                 cpu_stall
);

  localparam int unsigned CntW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CHAIN_LEN - 1);

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [1:0]             op_q;
  logic [CHAIN_LEN-1:0]   tx_q;
  logic [CHAIN_LEN-1:0]   rx_q;
  logic [CHAIN_LEN-1:0]   rd_image_q;
  logic                   cmd_ready_q;
  logic                   scan_en_q;
  logic                   done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= OpNop;
      tx_q        <= '0;
      rx_q        <= '0;
      rd_image_q  <= '0;
      cmd_ready_q <= 1'b1;
      scan_en_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // NOP is consumed by the handshake but never leaves idle.
          if (cmd_valid && cmd_ready_q && (cmd_op != OpNop)) begin
            op_q        <= cmd_op;
            tx_q        <= wr_image;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            scan_en_q   <= 1'b1;
            state_q     <= StShift;
          end
        end
        StShift: begin
          // tx drains LSB-first onto scan_in; rx fills from the top so bit k lands at k.
          tx_q <= tx_q >> 1;
          rx_q <= {scan_out, rx_q[CHAIN_LEN-1:1]};
          if (cnt_q == LastCnt) begin
            scan_en_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (op_q != OpWrite) begin
            rd_image_q <= rx_q;
          end
          done_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          scan_en_q   <= 1'b0;
          done_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  // READ feeds the chain back into itself so its contents survive the scan.
  always_comb begin
    scan_in = 1'b0;
    if (scan_en_q) begin
      scan_in = (op_q == OpRead) ? scan_out : tx_q[0];
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign scan_enable   = scan_en_q;
  assign done          = done_q;
  assign rd_image      = rd_image_q;
  assign cpu_stall     = (state_q != StIdle);
  assign csr_wr_enable = cpu_wr_enable & rst & (state_q == StIdle);

endmodule

// File: tb/tb_csr_scan_sequencer.sv
// Bench for csr_scan_sequencer: bit-level CSR chain as the environment, and an
// image-level model (chain contents, last read image) as the reference.
module tb_csr_scan_sequencer;

  localparam int unsigned L = 64;
  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;
  localparam logic [1:0] OpSwap  = 2'b11;
  localparam logic [L-1:0] ChainInit = 64'hDEADBEEF_CAFEF00D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [L-1:0] wr_image = '0;
  logic [L-1:0] rd_image;
  logic         done;
  logic         scan_enable;
  logic         scan_in;
  logic         scan_out;
  logic         cpu_wr_enable = 1'b0;
  logic         csr_wr_enable;
  logic         cpu_stall;

  csr_scan_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .wr_image      (wr_image),
    .rd_image      (rd_image),
    .done          (done),
    .scan_enable   (scan_enable),
    .scan_in       (scan_in),
    .scan_out      (scan_out),
    .cpu_wr_enable (cpu_wr_enable),
    .csr_wr_enable (csr_wr_enable),
    .cpu_stall     (cpu_stall)
  );

  always #5 clk = ~clk;

  // Physical CSR chain: bit 0 is the chain output, scan_in enters at the top.
  logic [L-1:0] chain = ChainInit;
  always @(posedge clk) begin
    if (scan_enable) chain <= {scan_in, chain[L-1:1]};
  end
  assign scan_out = chain[0];

  // Per-cycle activity totals, sampled at the edge that ends each cycle.
  int se_total = 0, done_total = 0, stall_total = 0, badwr_total = 0;
  always @(posedge clk) begin
    se_total    <= se_total + int'(scan_enable);
    done_total  <= done_total + int'(done);
    stall_total <= stall_total + int'(cpu_stall);
    badwr_total <= badwr_total + int'(cpu_stall && csr_wr_enable);
  end

  // Reference model: what the chain holds and what the last read returned.
  logic [L-1:0] ref_chain = ChainInit;
  logic [L-1:0] ref_rd = '0;
  bit           chain_known = 1'b1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [L-1:0] img);
    case (op)
      OpRead:  ref_rd = ref_chain;
      OpWrite: ref_chain = img;
      OpSwap:  begin ref_rd = ref_chain; ref_chain = img; end
      default: ;
    endcase
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [L-1:0] img, input string tag);
    int  se0, dn0, st0, bw0;
    bit  seen;
    @(negedge clk);
    check({tag, "_ready"}, L'(cmd_ready), L'(1'b1));
    check({tag, "_acc_wr"}, L'(csr_wr_enable), L'(cpu_wr_enable));
    se0 = se_total; dn0 = done_total; st0 = stall_total; bw0 = badwr_total;
    cmd_valid = 1'b1;
    cmd_op    = op;
    wr_image  = img;
    model_apply(op, img);
    if (op == OpNop) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check({tag, "_nop_ready"}, L'(cmd_ready), L'(1'b1));
      check({tag, "_nop_se"}, L'(se_total - se0), L'(0));
      check({tag, "_nop_done"}, L'(done_total - dn0), L'(0));
      check({tag, "_nop_rd"}, rd_image, ref_rd);
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        // The image must have been latched at accept; scramble what the host drives.
        wr_image = {$urandom, $urandom};
        if (done) seen = 1'b1;
      end
      cmd_valid = 1'b0;
      check({tag, "_done_seen"}, L'(seen), L'(1'b1));
      @(negedge clk);
      check({tag, "_idle_ready"}, L'(cmd_ready), L'(1'b1));
      check({tag, "_idle_stall"}, L'(cpu_stall), L'(1'b0));
      check({tag, "_rd"}, rd_image, ref_rd);
      check({tag, "_se_cycles"}, L'(se_total - se0), L'(L));
      check({tag, "_done_pulses"}, L'(done_total - dn0), L'(1));
      check({tag, "_stall_cycles"}, L'(stall_total - st0), L'(L + 1));
      check({tag, "_wr_gated"}, L'(badwr_total - bw0), L'(0));
      check({tag, "_idle_wr"}, L'(csr_wr_enable), L'(cpu_wr_enable));
      if (chain_known) check({tag, "_chain"}, chain, ref_chain);
    end
  endtask

  initial begin
    logic [L-1:0] a, b, img, rd_first;
    logic [1:0]   op;
    int           dn0;

    // Reset held for three cycles with a CPU write pending.
    cpu_wr_enable = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", L'(cmd_ready), L'(1'b1));
    check("rst_se", L'(scan_enable), L'(1'b0));
    check("rst_done", L'(done), L'(1'b0));
    check("rst_scan_in", L'(scan_in), L'(1'b0));
    check("rst_stall", L'(cpu_stall), L'(1'b0));
    check("rst_csr_wr", L'(csr_wr_enable), L'(1'b0));
    check("rst_rd", rd_image, '0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", L'(cmd_ready), L'(1'b1));
    check("post_rst_rd", rd_image, '0);
    check("post_rst_se", L'(scan_enable), L'(1'b0));
    check("post_rst_done", L'(done), L'(1'b0));
    check("post_rst_csr_wr", L'(csr_wr_enable), L'(1'b1));

    // Write then read back a known image, CPU writing throughout.
    run_cmd(OpWrite, 64'h0123456789ABCDEF, "wr1");
    run_cmd(OpRead, '0, "rd1");
    check("rd1_value", rd_image, 64'h0123456789ABCDEF);

    // Back-to-back reads are non-destructive.
    run_cmd(OpRead, '0, "rd2");
    rd_first = rd_image;
    run_cmd(OpRead, '0, "rd3");
    check("rd_repeat", rd_image, rd_first);

    // Swap returns the old image and leaves the new one.
    b = 64'hA5A5A5A5A5A5A5A5;
    a = 64'h5A5A5A5A5A5A5A5A;
    run_cmd(OpWrite, b, "wr_b");
    run_cmd(OpSwap, a, "swap_a");
    check("swap_rd_b", rd_image, b);
    run_cmd(OpRead, '0, "rd_a");
    check("read_after_swap", rd_image, a);

    run_cmd(OpNop, 64'hFFFF_FFFF_FFFF_FFFF, "nop");

    // Random command mix.
    for (int i = 0; i < 10; i++) begin
      op  = 2'($urandom_range(0, 3));
      img = {$urandom, $urandom};
      cpu_wr_enable = 1'($urandom_range(0, 1));
      run_cmd(op, img, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a shift.
    cpu_wr_enable = 1'b1;
    @(negedge clk);
    dn0 = done_total;
    cmd_valid = 1'b1;
    cmd_op    = OpWrite;
    wr_image  = {$urandom, $urandom};
    @(posedge clk);
    repeat (30) @(posedge clk);
    #2;
    check("mid_se_before", L'(scan_enable), L'(1'b1));
    rst = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("mid_rst_se", L'(scan_enable), L'(1'b0));
    check("mid_rst_done", L'(done), L'(1'b0));
    check("mid_rst_ready", L'(cmd_ready), L'(1'b1));
    check("mid_rst_rd", rd_image, '0);
    chain_known = 1'b0;
    ref_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_post_ready", L'(cmd_ready), L'(1'b1));
    check("mid_no_done", L'(done_total - dn0), L'(0));
    img = {$urandom, $urandom};
    run_cmd(OpWrite, img, "mid_wr");
    chain_known = 1'b1;
    run_cmd(OpRead, '0, "mid_rd");
    check("mid_roundtrip", rd_image, img);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csr_scan_sequencer.md
CSR_SCAN_SEQUENCER -- requirements
Module: csr_scan_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, bits per CSR.
REQ-002 Parameter NREGS, default 8, CSRs on the scan chain; CHAIN_LEN = WIDTH*NREGS (64 by default).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  host command request.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_op  in  2  00 NOP, 01 READ, 10 WRITE, 11 SWAP.
REQ-008 wr_image  in  CHAIN_LEN  image to load into the chain (WRITE/SWAP).
REQ-009 rd_image  out  CHAIN_LEN  last captured chain image.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 scan_enable  out  1  drives the CSR bank scan_enable.
REQ-012 scan_in  out  1  drives the CSR bank chain input.
REQ-013 scan_out  in  1  CSR bank chain output.
REQ-014 cpu_wr_enable  in  1  CPU CSR write request.
REQ-015 csr_wr_enable  out  1  gated write enable to the CSR bank.
REQ-016 cpu_stall  out  1  CPU must hold its CSR access.

Function
REQ-017 FSM states: IDLE, SHIFT, DONE; the FSM SHALL stay in IDLE on reset release.
REQ-018 IDLE: cmd_ready=1; handshake = cmd_valid & cmd_ready at a rising edge.
REQ-019 Accepted NOP: consumed; FSM stays in IDLE; no done pulse; no shift.
REQ-020 Accepted READ/WRITE/SWAP: latch op and wr_image into tx buffer, clear shift counter, go SHIFT next cycle.
REQ-021 SHIFT: scan_enable=1 for exactly CHAIN_LEN consecutive cycles; counter width clog2(CHAIN_LEN); transition to DONE after count CHAIN_LEN-1.
REQ-022 Shift cycle k (0-based): scan_in = scan_out for READ (rotate, non-destructive); scan_in = tx bit k for WRITE/SWAP.
REQ-023 Capture: on each SHIFT edge, rx buffer shifts right with scan_out entering the MSB, so after CHAIN_LEN shifts rx bit k = bit emitted at cycle k.
REQ-024 DONE: one cycle; done=1; scan_enable=0; cmd_ready=0; rd_image <= rx buffer for READ/SWAP, unchanged for WRITE; next state IDLE.
REQ-025 Consequence of REQ-022/023: WRITE X followed by READ SHALL return rd_image == X.
REQ-026 cmd_ready=0 in SHIFT and DONE; cmd_valid in those states is ignored (host holds it).
REQ-027 cpu_stall = (state != IDLE).
REQ-028 csr_wr_enable = cpu_wr_enable & (state == IDLE).
REQ-029 A CPU write in the cycle a command is accepted SHALL pass, since scan_enable first rises the following cycle.
REQ-030 scan_enable, scan_in, csr_wr_enable, cpu_stall and done SHALL be registered or decoded from state only; no combinational path from cmd_valid to scan_enable.
REQ-031 Input cmd_op values are always legal (2-bit full decode).

Reset
REQ-032 rst low SHALL force IDLE immediately (asynchronous), with cmd_ready=1 and all other outputs 0: scan_enable, scan_in, done, cpu_stall, csr_wr_enable gated to 0, rd_image all zero.
REQ-033 Reset mid-SHIFT: scan_enable drops asynchronously; chain contents are undefined (partial rotation); no done pulse; rd_image=0.
REQ-034 Counter, tx and rx buffers SHALL clear to 0 on reset.

Verification
REQ-035 Reset: assert rst low for 3 cycles, then release -> cmd_ready=1, rd_image=0, scan_enable=0, done=0.
REQ-036 WRITE 64'h0123456789ABCDEF, then READ -> scan_enable high exactly 64 cycles per command; done pulses once per command; rd_image=64'h0123456789ABCDEF.
REQ-037 Two back-to-back READs -> identical rd_image; chain model contents unchanged.
REQ-038 WRITE B=64'hA5A5..., then SWAP A=64'h5A5A... -> rd_image=B; following READ -> rd_image=A.
REQ-039 cpu_wr_enable=1 throughout a command -> csr_wr_enable=1 in the accept cycle; csr_wr_enable=0 and cpu_stall=1 for all 65 SHIFT/DONE cycles; csr_wr_enable=1 again on return to IDLE.
REQ-040 rst low at shift cycle 30 -> scan_enable=0 same cycle; no done pulse; after release, cmd_ready=1 and a new WRITE/READ pair round-trips correctly.
